// File: rtl/ascon_ctrl_fsm.sv
// Round sequencer for the one-round-per-clock ASCON-128 permutation datapath.
// Walks init, AD blocks, PT blocks and finalization; pulls 64-bit blocks over valid/ready.
module ascon_ctrl_fsm #(
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic       data_last_i,
    output logic       data_ready_o,
    output logic       selectionp_o,
    output logic       en_perm_o,
    output logic [3:0] round_o,
    output logic       en_xor_data_b_o,
    output logic       en_xor_key_b_o,
    output logic       en_xor_key_e_o,
    output logic       en_xor_lsb_e_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_WAIT_AD = 3'd2,
        S_AD      = 3'd3,
        S_WAIT_PT = 3'd4,
        S_PT      = 3'd5,
        S_FINAL   = 3'd6,
        S_DONE    = 3'd7
    } state_e;

    // Round 0 of AD/PT/FINAL is issued from the WAIT state, so the counter in those
    // states holds "rounds done after the first" and the round index is base+1+count.
    localparam logic [3:0] BASE_B   = 4'(ROUNDS_A - ROUNDS_B);
    localparam logic [3:0] INIT_END = 4'(ROUNDS_A - 1);
    localparam logic [3:0] FIN_END  = 4'(ROUNDS_A - 2);
    localparam logic [3:0] BLK_END  = 4'(ROUNDS_B - 2);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;

    // State, round counter and latched AD-last flag
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state and per-cycle datapath controls
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        last_d          = last_q;
        data_ready_o    = 1'b0;
        selectionp_o    = 1'b0;
        en_perm_o       = 1'b0;
        round_o         = 4'd0;
        en_xor_data_b_o = 1'b0;
        en_xor_key_b_o  = 1'b0;
        en_xor_key_e_o  = 1'b0;
        en_xor_lsb_e_o  = 1'b0;
        en_cipher_o     = 1'b0;
        en_tag_o        = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = S_INIT;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_INIT: begin
                en_perm_o    = 1'b1;
                round_o      = cnt_q;
                selectionp_o = (cnt_q == 4'd0);
                if (cnt_q == INIT_END) begin
                    en_xor_key_e_o = 1'b1;
                    state_d        = S_WAIT_AD;
                    cnt_d          = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_WAIT_AD: begin
                if (data_valid_i) begin
                    data_ready_o    = 1'b1;
                    en_perm_o       = 1'b1;
                    en_xor_data_b_o = 1'b1;
                    round_o         = BASE_B;
                    last_d          = data_last_i;
                    state_d         = S_AD;
                    cnt_d           = 4'd0;
                end else begin
                    state_d = S_WAIT_AD;
                end
            end

            S_AD: begin
                en_perm_o = 1'b1;
                round_o   = BASE_B + 4'd1 + cnt_q;
                if (cnt_q == BLK_END) begin
                    cnt_d = 4'd0;
                    if (last_q) begin
                        en_xor_lsb_e_o = 1'b1;
                        state_d        = S_WAIT_PT;
                    end else begin
                        state_d = S_WAIT_AD;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_WAIT_PT: begin
                if (data_valid_i) begin
                    data_ready_o    = 1'b1;
                    en_perm_o       = 1'b1;
                    en_xor_data_b_o = 1'b1;
                    en_cipher_o     = 1'b1;
                    cnt_d           = 4'd0;
                    if (data_last_i) begin
                        // Last PT block doubles as finalization round 0
                        en_xor_key_b_o = 1'b1;
                        round_o        = 4'd0;
                        state_d        = S_FINAL;
                    end else begin
                        round_o = BASE_B;
                        state_d = S_PT;
                    end
                end else begin
                    state_d = S_WAIT_PT;
                end
            end

            S_PT: begin
                en_perm_o = 1'b1;
                round_o   = BASE_B + 4'd1 + cnt_q;
                if (cnt_q == BLK_END) begin
                    cnt_d   = 4'd0;
                    state_d = S_WAIT_PT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_FINAL: begin
                en_perm_o = 1'b1;
                round_o   = 4'd1 + cnt_q;
                if (cnt_q == FIN_END) begin
                    en_xor_key_e_o = 1'b1;
                    cnt_d          = 4'd0;
                    state_d        = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                en_tag_o = 1'b1;
                done_o   = 1'b1;
                cnt_d    = 4'd0;
                state_d  = S_IDLE;
            end

            default: begin
                busy_o  = 1'b0;
                cnt_d   = 4'd0;
                last_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Self-checking bench: expected per-cycle control trace is assembled from phase templates
// (init / AD block / PT block / final / done) and compared cycle by cycle with the DUT.
module tb_ascon_ctrl_fsm;
    localparam int RA = 12;
    localparam int RB = 6;

    typedef struct packed {
        logic       ready;
        logic       selp;
        logic       perm;
        logic [3:0] round;
        logic       data_b;
        logic       key_b;
        logic       key_e;
        logic       lsb_e;
        logic       cipher;
        logic       tag;
        logic       busy;
        logic       done;
    } outv_t;

    typedef struct packed {
        logic start;
        logic valid;
        logic last;
    } inv_t;

    logic clk = 1'b0;
    logic rst;
    logic start, valid, last;
    logic ready_o, selp_o, perm_o, keyb_o, keye_o, lsb_o, cipher_o, tag_o, busy_o, done_o, datab_o;
    logic [3:0] round_o;

    always #5 clk = ~clk;

    ascon_ctrl_fsm #(.ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start),
        .data_valid_i(valid), .data_last_i(last), .data_ready_o(ready_o),
        .selectionp_o(selp_o), .en_perm_o(perm_o), .round_o(round_o),
        .en_xor_data_b_o(datab_o), .en_xor_key_b_o(keyb_o), .en_xor_key_e_o(keye_o),
        .en_xor_lsb_e_o(lsb_o), .en_cipher_o(cipher_o), .en_tag_o(tag_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    outv_t exp_q[$];
    inv_t  stim_q[$];
    int checks = 0;
    int failures = 0;
    int n_ready, n_cipher, n_lsb, n_keyb, n_done, done_cyc, lsb_cyc, keye_first, keye_last;

    function automatic logic junk();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outv_t dut_out();
        outv_t o;
        o.ready = ready_o; o.selp = selp_o; o.perm = perm_o; o.round = round_o;
        o.data_b = datab_o; o.key_b = keyb_o; o.key_e = keye_o; o.lsb_e = lsb_o;
        o.cipher = cipher_o; o.tag = tag_o; o.busy = busy_o; o.done = done_o;
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic add(input outv_t o, input logic s, input logic v, input logic l);
        inv_t i;
        i.start = s; i.valid = v; i.last = l;
        exp_q.push_back(o);
        stim_q.push_back(i);
    endtask

    // Expected trace: start, p12 init, AD blocks, PT blocks (last one opens p12 final), done.
    task automatic build(input int n_ad, input int n_pt, input int ad_stall,
                         input int pt_stall, input int pt_stall_idx, input bit noise);
        outv_t o;
        logic  sn;
        exp_q.delete();
        stim_q.delete();
        add('0, 1'b1, junk(), junk());
        for (int r = 0; r < RA; r++) begin
            o = '0; o.busy = 1'b1; o.perm = 1'b1; o.round = 4'(r);
            o.selp = (r == 0); o.key_e = (r == RA - 1);
            sn = noise ? junk() : 1'b0;
            add(o, sn, junk(), junk());
        end
        for (int k = 0; k < n_ad; k++) begin
            for (int s = 0; s < ad_stall; s++) begin
                o = '0; o.busy = 1'b1;
                add(o, noise ? junk() : 1'b0, 1'b0, junk());
            end
            for (int r = 0; r < RB; r++) begin
                o = '0; o.busy = 1'b1; o.perm = 1'b1; o.round = 4'(RA - RB + r);
                if (r == 0) begin o.ready = 1'b1; o.data_b = 1'b1; end
                if (r == RB - 1 && k == n_ad - 1) o.lsb_e = 1'b1;
                sn = noise ? junk() : 1'b0;
                if (r == 0) add(o, sn, 1'b1, 1'(k == n_ad - 1));
                else        add(o, sn, junk(), junk());
            end
        end
        for (int k = 0; k < n_pt; k++) begin
            for (int s = 0; s < ((k == pt_stall_idx) ? pt_stall : 0); s++) begin
                o = '0; o.busy = 1'b1;
                add(o, noise ? junk() : 1'b0, 1'b0, junk());
            end
            for (int r = 0; r < ((k == n_pt - 1) ? RA : RB); r++) begin
                o = '0; o.busy = 1'b1; o.perm = 1'b1;
                if (k == n_pt - 1) begin
                    o.round = 4'(r);
                    o.key_b = (r == 0);
                    o.key_e = (r == RA - 1);
                end else begin
                    o.round = 4'(RA - RB + r);
                end
                if (r == 0) begin o.ready = 1'b1; o.data_b = 1'b1; o.cipher = 1'b1; end
                sn = noise ? junk() : 1'b0;
                if (r == 0) add(o, sn, 1'b1, 1'(k == n_pt - 1));
                else        add(o, sn, junk(), junk());
            end
        end
        o = '0; o.busy = 1'b1; o.tag = 1'b1; o.done = 1'b1;
        add(o, 1'b0, junk(), junk());
        for (int t = 0; t < 3; t++) add('0, 1'b0, junk(), junk());
    endtask

    // Single compare point: drive after the rising edge, check at the falling edge.
    task automatic run_plan(input int n);
        outv_t act;
        n_ready = 0; n_cipher = 0; n_lsb = 0; n_keyb = 0; n_done = 0;
        done_cyc = -1; lsb_cyc = -1; keye_first = -1; keye_last = -1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            start = stim_q[c].start;
            valid = stim_q[c].valid;
            last  = stim_q[c].last;
            @(negedge clk);
            act = dut_out();
            checks++;
            if (act !== exp_q[c]) begin
                failures++;
                $display("FAIL trace cycle %0d: got %h expected %h", c, act, exp_q[c]);
            end
            if (act.ready)  n_ready++;
            if (act.cipher) n_cipher++;
            if (act.key_b)  n_keyb++;
            if (act.lsb_e) begin n_lsb++; lsb_cyc = c; end
            if (act.done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
            if (act.key_e) begin if (keye_first < 0) keye_first = c; keye_last = c; end
        end
        start = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'(dut_out()), 0);
        rst = 1'b0;

        // 1: minimal message, valid always present
        build(1, 1, 0, 0, -1, 1'b0);
        chk("s1_trace_len", exp_q.size(), 35);
        run_plan(exp_q.size());
        chk("s1_done_cycle", done_cyc, 31);
        chk("s1_lsb_cycle", lsb_cyc, 18);
        chk("s1_keye_first", keye_first, 12);
        chk("s1_keye_last", keye_last, 30);
        chk("s1_done_count", n_done, 1);

        // 2: 2 AD + 3 PT
        build(2, 3, 0, 0, -1, 1'b0);
        run_plan(exp_q.size());
        chk("s2_ready_pulses", n_ready, 5);
        chk("s2_cipher_pulses", n_cipher, 3);
        chk("s2_lsb_pulses", n_lsb, 1);
        chk("s2_keyb_pulses", n_keyb, 1);
        chk("s2_done_pulses", n_done, 1);

        // 3 + 6: stalls in WAIT_AD and WAIT_PT with data_last toggling while invalid
        build(1, 2, 2, 4, 1, 1'b0);
        run_plan(exp_q.size());
        chk("s3_ready_pulses", n_ready, 3);
        chk("s3_done_cycle", done_cyc, 31 + 2 + 6 + 4);

        // 4: start noise during every busy phase
        build(1, 1, 0, 0, -1, 1'b1);
        run_plan(exp_q.size());
        chk("s4_done_cycle", done_cyc, 31);
        chk("s4_done_count", n_done, 1);

        // 5: reset during FINAL round 5, then a clean run
        build(1, 1, 0, 0, -1, 1'b0);
        run_plan(24);
        @(posedge clk);
        #1;
        chk("s5_round_before_reset", int'(round_o), 5);
        rst = 1'b1;
        #1;
        chk("s5_outputs_in_reset", int'(dut_out()), 0);
        chk("s5_busy_in_reset", int'(busy_o), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("s5_idle_after_reset", int'(dut_out()), 0);
        build(1, 1, 0, 0, -1, 1'b0);
        run_plan(exp_q.size());
        chk("s5_done_cycle", done_cyc, 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
